cnt3_pwm: RTL

Downstream consumer of the free-running 3-bit binary counter (q3 MSB, q1 LSB, +1 mod 8 every clk). Turns the count into an 8-slot PWM waveform with a glitch-free duty update at period boundaries. Also checks that the incoming count really advances by one each cycle, and re-locks after any discontinuity. Sits between the counter and the output drivers/LED stage.

---
 rtl/cnt3_pkg.sv | 25 ++
 rtl/cnt3_seq_check.sv | 58 +++++
 rtl/cnt3_pwm.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cnt3_pkg.sv
// -----------------------------------------------------------------------------
// cnt3_pkg
// Shared definitions for the 3-bit-counter PWM stage: period geometry, the
// lock FSM state type and the duty clip helper.
// -----------------------------------------------------------------------------
package cnt3_pkg;

  // Slots per PWM period; tied to the 3-bit counter, so not a parameter.
  localparam int PERIOD = 8;
  // Counter width.
  localparam int CW = 3;
  // Duty request width (0..15, meaningful range 0..PERIOD).
  localparam int DW = 4;

  typedef enum logic {
    SYNC = 1'b0,  // waiting for c == 0 to align with the counter
    RUN  = 1'b1   // aligned; count is checked every cycle
  } state_e;

  // Requests above one full period saturate to "always high".
  function automatic logic [DW-1:0] clip_duty(input logic [DW-1:0] d);
    return (d > DW'(PERIOD)) ? DW'(PERIOD) : d;
  endfunction

endpackage

// File: rtl/cnt3_seq_check.sv
// -----------------------------------------------------------------------------
// cnt3_seq_check
// Tracks the previously sampled count and flags any sample that is not the
// previous one plus one (mod 8). Keeps a saturating count of flagged
// discontinuities while the caller enables counting.
//
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-high
//   c_i          in   sampled counter value {q3,q2,q1}
//   count_en_i   in   a mismatch this cycle is a real error (locked only)
//   mismatch_o   out  combinational: c_i differs from the expected value
//   err_count_o  out  saturating count of enabled mismatches
// -----------------------------------------------------------------------------
module cnt3_seq_check
  import cnt3_pkg::*;
#(
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CW-1:0]   c_i,
  input  logic            count_en_i,
  output logic            mismatch_o,
  output logic [ERRW-1:0] err_count_o
);

  logic [CW-1:0]   prev_q;
  logic [CW-1:0]   expected;
  logic [ERRW-1:0] err_q;
  logic [ERRW-1:0] err_d;

  // CW-bit add wraps 7 -> 0, which is the legal counter rollover.
  assign expected   = prev_q + CW'(1);
  assign mismatch_o = (c_i != expected);

  always_comb begin
    err_d = err_q;
    if (count_en_i && mismatch_o && (err_q != '1)) begin
      err_d = err_q + ERRW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (reset) begin
      prev_q <= '0;
      err_q  <= '0;
    end else begin
      prev_q <= c_i;
      err_q  <= err_d;
    end
  end

  assign err_count_o = err_q;

endmodule

// File: rtl/cnt3_pwm.sv
// -----------------------------------------------------------------------------
// cnt3_pwm
// Turns the free-running 3-bit count into an 8-slot PWM waveform. A new duty
// value is taken through a one-deep valid/ready holding register and applied
// only on the last slot of a period, so the waveform never glitches mid-period.
// The count is checked every locked cycle; a discontinuity drops lock until
// the counter next shows 0.
//
// Ports
//   clk           in   clock shared with the counter
//   reset         in   synchronous, active-high
//   q1, q2, q3    in   counter bits (q1 = LSB)
//   duty_in       in   requested high slots per period (9..15 clip to 8)
//   duty_valid    in   duty_in is valid
//   duty_ready    out  holding register is empty
//   pwm_out       out  registered PWM output
//   period_start  out  one-cycle pulse, one cycle after a locked c == 0
//   locked        out  FSM is in RUN
//   seq_err       out  one-cycle pulse, one cycle after a bad sample
//   err_count     out  saturating count of discontinuities
// -----------------------------------------------------------------------------
module cnt3_pwm
  import cnt3_pkg::*;
#(
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            q1,
  input  logic            q2,
  input  logic            q3,
  input  logic [DW-1:0]   duty_in,
  input  logic            duty_valid,
  output logic            duty_ready,
  output logic            pwm_out,
  output logic            period_start,
  output logic            locked,
  output logic            seq_err,
  output logic [ERRW-1:0] err_count
);

  logic [CW-1:0] c;
  logic          mismatch;
  logic          accept;

  state_e        state_q, state_d;
  logic          pwm_q, pwm_d;
  logic          ps_q, ps_d;
  logic          serr_q, serr_d;
  logic [DW-1:0] duty_act_q, duty_act_d;
  logic [DW-1:0] pend_q, pend_d;
  logic          pend_v_q, pend_v_d;

  // A cycle that behaves as RUN: locked with a good count, or the locking
  // cycle itself (SYNC sampling 0).
  logic          run_ok;
  logic          apply;

  assign c      = {q3, q2, q1};
  assign accept = duty_valid && !pend_v_q;

  cnt3_seq_check #(
    .ERRW (ERRW)
  ) u_seq_check (
    .clk         (clk),
    .reset       (reset),
    .c_i         (c),
    .count_en_i  (state_q == RUN),
    .mismatch_o  (mismatch),
    .err_count_o (err_count)
  );

  always_comb begin
    // NOTE: every signal driven here gets its default first, so no branch
    // can leave one unassigned and infer a latch.
    state_d    = state_q;
    run_ok     = 1'b0;
    serr_d     = 1'b0;
    duty_act_d = duty_act_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;

    case (state_q)
      SYNC: begin
        if (c == '0) begin
          state_d = RUN;
          run_ok  = 1'b1;
        end
      end
      RUN: begin
        if (mismatch) begin
          state_d = SYNC;
          serr_d  = 1'b1;
        end else begin
          run_ok = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase

    // Slot c is high while c is below the active duty; the compare uses the
    // duty that governs the current period even on its last slot.
    pwm_d = run_ok && ({1'b0, c} < duty_act_q);
    ps_d  = run_ok && (c == '0);
    apply = run_ok && (c == CW'(PERIOD - 1));

    if (apply && accept) begin
      // Value arriving exactly on the apply slot skips the holding register.
      duty_act_d = clip_duty(duty_in);
    end else begin
      if (apply && pend_v_q) begin
        duty_act_d = pend_q;
        pend_v_d   = 1'b0;
      end
      if (accept) begin
        pend_d   = clip_duty(duty_in);
        pend_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SYNC;
      pwm_q      <= 1'b0;
      ps_q       <= 1'b0;
      serr_q     <= 1'b0;
      duty_act_q <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwm_q      <= pwm_d;
      ps_q       <= ps_d;
      serr_q     <= serr_d;
      duty_act_q <= duty_act_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
    end
  end

  assign duty_ready   = !pend_v_q;
  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign locked       = (state_q == RUN);
  assign seq_err      = serr_q;

endmodule
